// File: rtl/uart2wifi_core_linebuf.sv
// uart2wifi_core_linebuf: assembles UART RX bytes into a line buffer (CR stripped, backspace edit) for the command side.
// Optional echo toward UART TX when UART2WIFI_LINEBUF_ECHO_EN is defined.
module uart2wifi_core_linebuf #(
  parameter int DEPTH = 64,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     line_ready,
  output logic [LEN_W-1:0]         line_len,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  input  logic                     line_ack,
  output logic                     ovf_err,
  output logic                     overrun_err,
  output logic                     echo_valid,
  output logic [7:0]               echo_data
);
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A, BS = 8'h08;
  typedef enum logic [1:0] {COLLECT, DISCARD, READY} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d, len_q, len_d;
  logic [7:0] rd_data_q;
  logic ovf_q, ovf_d, overrun_q, overrun_d, we;
  logic [7:0] mem [DEPTH];
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    len_d = len_q;
    ovf_d = 1'b0;
    overrun_d = 1'b0;
    we = 1'b0;
    case (state_q)
      COLLECT: if (rx_valid) begin
        if (rx_data == LF) begin
          len_d = wr_ptr_q;
          state_d = READY;
        end else if (rx_data == BS) begin
          wr_ptr_d = (wr_ptr_q != '0) ? wr_ptr_q - 1'b1 : wr_ptr_q;
        end else if (rx_data != CR) begin
          if (wr_ptr_q == LEN_W'(DEPTH)) begin
            ovf_d = 1'b1;
            state_d = DISCARD;
          end else begin
            we = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      DISCARD: if (rx_valid && rx_data == LF) begin
        wr_ptr_d = '0;
        state_d = COLLECT;
      end
      READY: begin
        overrun_d = rx_valid;
        if (line_ack) begin
          wr_ptr_d = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      wr_ptr_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
      overrun_q <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
      overrun_q <= overrun_d;
      rd_data_q <= mem[rd_addr];
    end
  end
  // Buffer storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[$clog2(DEPTH)-1:0]] <= rx_data;
  end
  assign line_ready = (state_q == READY);
  assign line_len = len_q;
  assign rd_data = rd_data_q;
  assign ovf_err = ovf_q;
  assign overrun_err = overrun_q;
`ifdef UART2WIFI_LINEBUF_ECHO_EN
  logic echo_valid_q, lf_q;
  logic [7:0] echo_data_q;
  logic acc;
  assign acc = we || (state_q == COLLECT && rx_valid && (rx_data == LF || (rx_data == BS && wr_ptr_q != '0)));
  // LF is echoed as CR then LF; the LF half is replayed from lf_q a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_valid_q <= 1'b0;
      echo_data_q <= 8'h00;
      lf_q <= 1'b0;
    end else begin
      echo_valid_q <= acc || lf_q;
      echo_data_q <= lf_q ? LF : (acc ? ((rx_data == LF) ? CR : rx_data) : echo_data_q);
      lf_q <= acc && rx_data == LF;
    end
  end
  assign echo_valid = echo_valid_q;
  assign echo_data = echo_data_q;
`else
  assign echo_valid = 1'b0;
  assign echo_data = 8'h00;
`endif
endmodule
